// File: rtl/tdc_measure_ctrl.sv
// tdc_measure_ctrl: sequences one TDC measurement.
// The block arms the delay line, counts coarse clock cycles from the start hit
// to the stop hit, and waits out the decoder latency. It then merges the coarse
// count with the start and stop fine bins into one interval, measured in bins,
// and presents it on a valid/ready result port.
//
// Optional build macro: TDC_STATS_CNT_EN adds the meas_count_o and
// timeout_count_o statistics counters.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for arm_i
// S_ARMED   | delay line armed, coarse counter held at 0, waiting for start
// S_RUNNING | coarse counter running, waiting for stop
// S_DECODE  | waiting for the start/stop decoder bins to become valid
// S_OUT     | result presented, waiting for the res_ready_i handshake

module tdc_measure_ctrl #(
   parameter int BITS_DECO    = 8,
   parameter int COARSE_BITS  = 16,
   parameter int BINS_PER_CLK = 200,
   parameter int DECODE_LAT   = 2,
   parameter int RES_BITS     = COARSE_BITS + BITS_DECO + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 arm_i,
   input  logic                 abort_i,
   input  logic                 start_hit_i,
   input  logic                 stop_hit_i,
   input  logic [BITS_DECO-1:0] w_start_bin_i,
   input  logic [BITS_DECO-1:0] w_stop_bin_i,
   output logic                 armed_o,
   output logic                 busy_o,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic [RES_BITS-1:0]  res_interval_o,
   output logic                 res_timeout_o,
`ifdef TDC_STATS_CNT_EN
   output logic [15:0]          meas_count_o,
   output logic [15:0]          timeout_count_o,
`endif
   output logic                 res_neg_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_RUNNING,
      S_DECODE,
      S_OUT
   } state_t;

   // One extra bit holds the sign of the raw interval.
   typedef logic [RES_BITS:0] ext_t;

   localparam logic [COARSE_BITS-1:0] COARSE_ONE  = COARSE_BITS'(1);
   // The edge that would bring the counter to all ones ends the measurement.
   localparam logic [COARSE_BITS-1:0] COARSE_LAST = {{(COARSE_BITS-1){1'b1}}, 1'b0};
   localparam logic [3:0]             LAT_LOAD    = 4'((DECODE_LAT > 0) ? DECODE_LAT - 1 : 0);
   localparam ext_t                   BINS_EXT    = ext_t'(BINS_PER_CLK);

   state_t                state_q;
   logic [COARSE_BITS-1:0] coarse_q;
   logic [3:0]            lat_q;
   logic                  armed_q;
   logic                  busy_q;
   logic                  res_valid_q;
   logic [RES_BITS-1:0]   res_interval_q;
   logic                  res_timeout_q;
   logic                  res_neg_q;

   ext_t                  raw_d;
   logic [RES_BITS-1:0]   interval_d;
   logic                  neg_d;
   logic                  stop_now;

   // Interval from the current coarse count and bins; a negative value is clamped to 0.
   always_comb begin
      raw_d      = ext_t'(coarse_q) * BINS_EXT + ext_t'(w_start_bin_i) - ext_t'(w_stop_bin_i);
      neg_d      = raw_d[RES_BITS];
      interval_d = neg_d ? '0 : raw_d[RES_BITS-1:0];
   end

   // The stop hit is taken in RUNNING, or in ARMED when it coincides with the start hit.
   always_comb begin
      stop_now = ((state_q == S_RUNNING) && stop_hit_i) ||
                 ((state_q == S_ARMED) && start_hit_i && stop_hit_i);
   end

   // Measurement sequencer with registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= S_IDLE;
         coarse_q       <= '0;
         lat_q          <= '0;
         armed_q        <= 1'b0;
         busy_q         <= 1'b0;
         res_valid_q    <= 1'b0;
         res_interval_q <= '0;
         res_timeout_q  <= 1'b0;
         res_neg_q      <= 1'b0;
      end else if (abort_i) begin
         state_q     <= S_IDLE;
         armed_q     <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arm_i) begin
                  state_q       <= S_ARMED;
                  armed_q       <= 1'b1;
                  busy_q        <= 1'b1;
                  coarse_q      <= '0;
                  res_timeout_q <= 1'b0;
                  res_neg_q     <= 1'b0;
               end
            end
            S_ARMED, S_RUNNING: begin
               if (stop_now) begin
                  armed_q <= 1'b0;
                  if (DECODE_LAT == 0) begin
                     state_q        <= S_OUT;
                     res_valid_q    <= 1'b1;
                     res_interval_q <= interval_d;
                     res_neg_q      <= neg_d;
                  end else begin
                     state_q <= S_DECODE;
                     lat_q   <= LAT_LOAD;
                  end
               end else if (state_q == S_ARMED) begin
                  if (start_hit_i) begin
                     state_q  <= S_RUNNING;
                     coarse_q <= COARSE_ONE;
                  end
               end else if (coarse_q == COARSE_LAST) begin
                  state_q        <= S_OUT;
                  armed_q        <= 1'b0;
                  res_valid_q    <= 1'b1;
                  res_interval_q <= '1;
                  res_timeout_q  <= 1'b1;
                  res_neg_q      <= 1'b0;
               end else begin
                  coarse_q <= coarse_q + COARSE_ONE;
               end
            end
            S_DECODE: begin
               if (lat_q == 4'd0) begin
                  state_q        <= S_OUT;
                  res_valid_q    <= 1'b1;
                  res_interval_q <= interval_d;
                  res_neg_q      <= neg_d;
               end else begin
                  lat_q <= lat_q - 4'd1;
               end
            end
            S_OUT: begin
               if (res_ready_i) begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  res_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               armed_q     <= 1'b0;
               busy_q      <= 1'b0;
               res_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef TDC_STATS_CNT_EN
   logic [15:0] meas_count_q;
   logic [15:0] timeout_count_q;

   // Count accepted results; an abort in the handshake cycle takes precedence, so nothing is counted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meas_count_q    <= '0;
         timeout_count_q <= '0;
      end else if ((state_q == S_OUT) && res_ready_i && !abort_i) begin
         meas_count_q <= meas_count_q + 16'd1;
         if (res_timeout_q) begin
            timeout_count_q <= timeout_count_q + 16'd1;
         end
      end
   end

   assign meas_count_o    = meas_count_q;
   assign timeout_count_o = timeout_count_q;
`endif

   assign armed_o        = armed_q;
   assign busy_o         = busy_q;
   assign res_valid_o    = res_valid_q;
   assign res_interval_o = res_interval_q;
   assign res_timeout_o  = res_timeout_q;
   assign res_neg_o      = res_neg_q;

endmodule
